mem16_responder: RTL and testbench

Single-ported 16-bit word memory that answers the CPU's instruction-fetch port and its data read/write port. It is the target side of those request/ready handshakes and sits between the CPU core and on-chip block RAM. It serializes the three request sources onto one memory port with fixed priority and one-entry request latches. Each accepted request gets a single-cycle ready pulse after a configurable number of wait states.

---
 rtl/mem16_responder.sv | 167 ++++++++++++++++
 tb/tb_mem16_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem16_responder.sv
// mem16_responder: single-ported 16-bit word memory serving a CPU fetch port and a data port.
// Fixed priority WR > RD > IF with one-entry request latches and programmable wait states.
module mem16_responder #(
   parameter int    ADDR_BITS   = 8,
   parameter int    WAIT_STATES = 0,
   parameter string INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] ins_rd_addr,
   input  logic        ins_rd_req,
   output logic [15:0] ins_rd_data,
   output logic        ins_rd_rdy,
   input  logic [15:0] dat_rw_addr,
   input  logic [15:0] dat_wr_data,
   input  logic        dat_rd_req,
   input  logic        dat_wr_req,
   output logic [15:0] dat_rd_data,
   output logic        dat_rd_rdy,
   output logic        dat_wr_rdy
);
   localparam int         DEPTH    = 1 << ADDR_BITS;
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BUSY  = 1'b1;
   localparam logic       HAS_WAIT = (WAIT_STATES > 32'sd0);
   localparam logic [3:0] WS_LOAD  = HAS_WAIT ? 4'(WAIT_STATES - 32'sd1) : 4'd0;

   logic [15:0]          mem_r [DEPTH];

   logic                 wr_v_r, rd_v_r, if_v_r;
   logic [ADDR_BITS-1:0] wr_a_r, rd_a_r, if_a_r;
   logic [15:0]          wr_d_r;
   logic [0:0]           state_r;
   logic [3:0]           cnt_r;
   logic [2:0]           pend_r;

   logic                 wr_c_s, rd_c_s, if_c_s;
   logic [ADDR_BITS-1:0] wr_ca_s, rd_ca_s, if_ca_s, g_addr_s;
   logic [15:0]          wr_cd_s;
   logic [2:0]           grant_s;
   logic                 unused_s;

   // Upper address bits alias onto the decoded range.
   assign unused_s = ^{ins_rd_addr, dat_rw_addr};

   // Candidate selection: a latched entry beats that port's live request; grant bits are {if, rd, wr}.
   always_comb begin
      wr_c_s   = ~reset & (wr_v_r | dat_wr_req);
      rd_c_s   = ~reset & (rd_v_r | dat_rd_req);
      if_c_s   = ~reset & (if_v_r | ins_rd_req);
      wr_ca_s  = wr_v_r ? wr_a_r : dat_rw_addr[ADDR_BITS-1:0];
      wr_cd_s  = wr_v_r ? wr_d_r : dat_wr_data;
      rd_ca_s  = rd_v_r ? rd_a_r : dat_rw_addr[ADDR_BITS-1:0];
      if_ca_s  = if_v_r ? if_a_r : ins_rd_addr[ADDR_BITS-1:0];
      grant_s  = 3'b000;
      g_addr_s = if_ca_s;
      if (state_r == ST_IDLE) begin
         if (wr_c_s) begin
            grant_s  = 3'b001;
            g_addr_s = wr_ca_s;
         end else if (rd_c_s) begin
            grant_s  = 3'b010;
            g_addr_s = rd_ca_s;
         end else if (if_c_s) begin
            grant_s  = 3'b100;
         end else begin
            grant_s  = 3'b000;
         end
      end else begin
         grant_s = 3'b000;
      end
   end

   // Array write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (grant_s[0]) begin
         mem_r[g_addr_s] <= wr_cd_s;
      end
   end

   // Read data registers load only on their own port's grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         ins_rd_data <= 16'h0000;
         dat_rd_data <= 16'h0000;
      end else begin
         if (grant_s[1]) begin
            dat_rd_data <= mem_r[g_addr_s];
         end
         if (grant_s[2]) begin
            ins_rd_data <= mem_r[g_addr_s];
         end
      end
   end

   // Request latches: fill when empty and not granted, clear on grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_v_r <= 1'b0;
         rd_v_r <= 1'b0;
         if_v_r <= 1'b0;
         wr_a_r <= {ADDR_BITS{1'b0}};
         rd_a_r <= {ADDR_BITS{1'b0}};
         if_a_r <= {ADDR_BITS{1'b0}};
         wr_d_r <= 16'h0000;
      end else begin
         if (grant_s[0]) begin
            wr_v_r <= 1'b0;
         end else if (!wr_v_r && dat_wr_req) begin
            wr_v_r <= 1'b1;
            wr_a_r <= dat_rw_addr[ADDR_BITS-1:0];
            wr_d_r <= dat_wr_data;
         end
         if (grant_s[1]) begin
            rd_v_r <= 1'b0;
         end else if (!rd_v_r && dat_rd_req) begin
            rd_v_r <= 1'b1;
            rd_a_r <= dat_rw_addr[ADDR_BITS-1:0];
         end
         if (grant_s[2]) begin
            if_v_r <= 1'b0;
         end else if (!if_v_r && ins_rd_req) begin
            if_v_r <= 1'b1;
            if_a_r <= ins_rd_addr[ADDR_BITS-1:0];
         end
      end
   end

   // Wait-state sequencer; the ready pulse lands in the cycle the FSM is (back) in IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
         pend_r  <= 3'b000;
         {ins_rd_rdy, dat_rd_rdy, dat_wr_rdy} <= 3'b000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (HAS_WAIT && (grant_s != 3'b000)) begin
                  state_r <= ST_BUSY;
                  cnt_r   <= WS_LOAD;
                  pend_r  <= grant_s;
                  {ins_rd_rdy, dat_rd_rdy, dat_wr_rdy} <= 3'b000;
               end else begin
                  {ins_rd_rdy, dat_rd_rdy, dat_wr_rdy} <= grant_s;
               end
            end
            ST_BUSY: begin
               if (cnt_r == 4'd0) begin
                  state_r <= ST_IDLE;
                  pend_r  <= 3'b000;
                  {ins_rd_rdy, dat_rd_rdy, dat_wr_rdy} <= pend_r;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
                  {ins_rd_rdy, dat_rd_rdy, dat_wr_rdy} <= 3'b000;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= 4'd0;
               pend_r  <= 3'b000;
               {ins_rd_rdy, dat_rd_rdy, dat_wr_rdy} <= 3'b000;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem16_responder.sv
// tb_mem16_responder: two responders (0 and 3 wait states) share stimulus and are checked
// each cycle against a transaction-level model, plus directed latency/alias/reset scenarios.
module tb_mem16_responder;
   logic              clk = 1'b0;
   logic              reset;
   logic [15:0]       ins_rd_addr, dat_rw_addr, dat_wr_data;
   logic              ins_rd_req, dat_rd_req, dat_wr_req;
   logic [1:0]        ins_rdy, rd_rdy, wr_rdy;
   logic [1:0][15:0]  ins_data, rd_data;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model state, index 0 = no wait states, 1 = three wait states.
   logic [15:0] m_mem [2][256];
   bit          m_v   [2][3];
   logic [7:0]  m_a   [2][3];
   logic [15:0] m_wd  [2];
   int          m_free[2];
   int          m_sched[2];
   int          m_sport[2];
   logic [2:0]  e_rdy [2];
   logic [15:0] e_id  [2];
   logic [15:0] e_dd  [2];

   mem16_responder #(.ADDR_BITS(8), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
      .clk(clk), .reset(reset),
      .ins_rd_addr(ins_rd_addr), .ins_rd_req(ins_rd_req),
      .ins_rd_data(ins_data[0]), .ins_rd_rdy(ins_rdy[0]),
      .dat_rw_addr(dat_rw_addr), .dat_wr_data(dat_wr_data),
      .dat_rd_req(dat_rd_req), .dat_wr_req(dat_wr_req),
      .dat_rd_data(rd_data[0]), .dat_rd_rdy(rd_rdy[0]), .dat_wr_rdy(wr_rdy[0])
   );

   mem16_responder #(.ADDR_BITS(8), .WAIT_STATES(3), .INIT_FILE("")) dut3 (
      .clk(clk), .reset(reset),
      .ins_rd_addr(ins_rd_addr), .ins_rd_req(ins_rd_req),
      .ins_rd_data(ins_data[1]), .ins_rd_rdy(ins_rdy[1]),
      .dat_rw_addr(dat_rw_addr), .dat_wr_data(dat_wr_data),
      .dat_rd_req(dat_rd_req), .dat_wr_req(dat_wr_req),
      .dat_rd_data(rd_data[1]), .dat_rd_rdy(rd_rdy[1]), .dat_wr_rdy(wr_rdy[1])
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // One cycle of the reference: arbitrate, access, latch, schedule the completion.
   task automatic model_step(input int i);
      int         w;
      int         g;
      bit         rq [3];
      logic [7:0] ia [3];
      logic [7:0] a;
      w = (i == 0) ? 0 : 3;
      if (reset) begin
         for (int p = 0; p < 3; p++) m_v[i][p] = 1'b0;
         m_free[i]  = cyc + 1;
         m_sched[i] = -1;
         e_rdy[i]   = 3'b000;
         e_id[i]    = 16'h0000;
         e_dd[i]    = 16'h0000;
      end else begin
         rq[0] = dat_wr_req;
         rq[1] = dat_rd_req;
         rq[2] = ins_rd_req;
         ia[0] = dat_rw_addr[7:0];
         ia[1] = dat_rw_addr[7:0];
         ia[2] = ins_rd_addr[7:0];
         g = -1;
         if (cyc >= m_free[i]) begin
            for (int p = 0; p < 3; p++)
               if (g < 0 && (m_v[i][p] || rq[p])) g = p;
         end
         if (g >= 0) begin
            a = m_v[i][g] ? m_a[i][g] : ia[g];
            if (g == 0)      m_mem[i][a] = m_v[i][0] ? m_wd[i] : dat_wr_data;
            else if (g == 1) e_dd[i] = m_mem[i][a];
            else             e_id[i] = m_mem[i][a];
            m_sched[i] = cyc + 1 + w;
            m_sport[i] = g;
            m_free[i]  = cyc + 1 + w;
            m_v[i][g]  = 1'b0;
         end
         for (int p = 0; p < 3; p++) begin
            if (p != g && !m_v[i][p] && rq[p]) begin
               m_v[i][p] = 1'b1;
               m_a[i][p] = ia[p];
               if (p == 0) m_wd[i] = dat_wr_data;
            end
         end
         e_rdy[i] = (m_sched[i] == cyc + 1) ? (3'b001 << m_sport[i]) : 3'b000;
      end
   endtask

   // Compare every output of both instances against the model, then advance the model.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rdy_vec[%0d]", i), 32'({ins_rdy[i], rd_rdy[i], wr_rdy[i]}), 32'(e_rdy[i]));
         check($sformatf("ins_data[%0d]", i), 32'(ins_data[i]), 32'(e_id[i]));
         check($sformatf("rd_data[%0d]", i), 32'(rd_data[i]), 32'(e_dd[i]));
         model_step(i);
      end
      cyc++;
   end

   initial begin
      reset       = 1'b1;
      ins_rd_req  = 1'b0;
      dat_rd_req  = 1'b0;
      dat_wr_req  = 1'b0;
      ins_rd_addr = 16'h0000;
      dat_rw_addr = 16'h0000;
      dat_wr_data = 16'h0000;
      for (int i = 0; i < 2; i++) begin
         for (int p = 0; p < 3; p++) m_v[i][p] = 1'b0;
         m_free[i]  = 0;
         m_sched[i] = -1;
         m_sport[i] = 0;
         e_rdy[i]   = 3'b000;
         e_id[i]    = 16'h0000;
         e_dd[i]    = 16'h0000;
      end
      tick();
      tick();
      reset = 1'b0;

      // Preload mem[k] = k + 0x100 through the write port.
      for (int k = 0; k < 256; k++) begin
         dat_wr_req  = 1'b1;
         dat_rw_addr = 16'(k);
         dat_wr_data = 16'(16'h0100 + k);
         tick();
         dat_wr_req = 1'b0;
         idle(3);
      end
      idle(4);

      // Fetch stream with request held high.
      ins_rd_req  = 1'b1;
      ins_rd_addr = 16'h0000;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (k < 2) ins_rd_addr = 16'(k + 1);
         else       ins_rd_req  = 1'b0;
         @(negedge clk);
         check("fetch_rdy", 32'(ins_rdy[0]), 32'd1);
         check("fetch_data", 32'(ins_data[0]), 32'h0100 + 32'(k));
      end
      idle(12);

      // Write then read of the same address.
      dat_wr_req  = 1'b1;
      dat_rw_addr = 16'h0005;
      dat_wr_data = 16'hBEEF;
      tick();
      dat_wr_req = 1'b0;
      dat_rd_req = 1'b1;
      @(negedge clk);
      check("wr_rdy", 32'(wr_rdy[0]), 32'd1);
      check("rd_rdy_early", 32'(rd_rdy[0]), 32'd0);
      tick();
      dat_rd_req = 1'b0;
      @(negedge clk);
      check("rd_after_wr_rdy", 32'(rd_rdy[0]), 32'd1);
      check("rd_after_wr_data", 32'(rd_data[0]), 32'h0000BEEF);
      idle(12);

      // Three-way contention in one cycle.
      ins_rd_req  = 1'b1;
      ins_rd_addr = 16'h0003;
      dat_rd_req  = 1'b1;
      dat_wr_req  = 1'b1;
      dat_rw_addr = 16'h0007;
      dat_wr_data = 16'h1234;
      tick();
      ins_rd_req = 1'b0;
      dat_rd_req = 1'b0;
      dat_wr_req = 1'b0;
      @(negedge clk);
      check("cont_c1", 32'({ins_rdy[0], rd_rdy[0], wr_rdy[0]}), 32'b001);
      tick();
      @(negedge clk);
      check("cont_c2", 32'({ins_rdy[0], rd_rdy[0], wr_rdy[0]}), 32'b010);
      check("cont_rd_data", 32'(rd_data[0]), 32'h00001234);
      tick();
      @(negedge clk);
      check("cont_c3", 32'({ins_rdy[0], rd_rdy[0], wr_rdy[0]}), 32'b100);
      check("cont_if_data", 32'(ins_data[0]), 32'h00000103);
      idle(16);

      // Three wait states: read latency 4, fetch issued one cycle later waits in its latch.
      dat_rd_req  = 1'b1;
      dat_rw_addr = 16'h0009;
      tick();
      dat_rd_req  = 1'b0;
      ins_rd_req  = 1'b1;
      ins_rd_addr = 16'h0004;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         check("ws3_rd_rdy", 32'(rd_rdy[1]), 32'(c == 4));
         check("ws3_if_rdy", 32'(ins_rdy[1]), 32'(c == 8));
         if (c == 4) check("ws3_rd_data", 32'(rd_data[1]), 32'h00000109);
         if (c == 8) check("ws3_if_data", 32'(ins_data[1]), 32'h00000104);
         tick();
         if (c == 1) ins_rd_req = 1'b0;
      end
      idle(8);

      // Address aliasing above ADDR_BITS.
      dat_wr_req  = 1'b1;
      dat_rw_addr = 16'h0102;
      dat_wr_data = 16'hA5A5;
      tick();
      dat_wr_req = 1'b0;
      idle(3);
      dat_rd_req  = 1'b1;
      dat_rw_addr = 16'h0002;
      tick();
      dat_rd_req = 1'b0;
      idle(3);
      @(negedge clk);
      check("alias_rdy", 32'(rd_rdy[1]), 32'd1);
      check("alias_data3", 32'(rd_data[1]), 32'h0000A5A5);
      check("alias_data0", 32'(rd_data[0]), 32'h0000A5A5);
      idle(4);

      // Reset during a wait-stated read drops it; a later fetch completes normally.
      dat_rd_req  = 1'b1;
      dat_rw_addr = 16'h000A;
      tick();
      dat_rd_req = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         reset = (c == 2);
         @(negedge clk);
         check("rst_no_rdy", 32'({ins_rdy[1], rd_rdy[1], wr_rdy[1]}), 32'd0);
         if (c >= 3) check("rst_data_zero", 32'({ins_data[1], rd_data[1]}), 32'd0);
         tick();
      end
      reset       = 1'b0;
      ins_rd_req  = 1'b1;
      ins_rd_addr = 16'h000B;
      tick();
      ins_rd_req = 1'b0;
      for (int c = 8; c <= 11; c++) begin
         @(negedge clk);
         check("post_rst_if_rdy", 32'(ins_rdy[1]), 32'(c == 11));
         if (c == 11) check("post_rst_if_data", 32'(ins_data[1]), 32'h0000010B);
         tick();
      end
      idle(6);

      // Random traffic against the model, including long-held fetches and rare resets.
      for (int n = 0; n < 3000; n++) begin
         reset      = ($urandom_range(0, 199) == 0);
         dat_wr_req = ($urandom_range(0, 3) == 0);
         dat_rd_req = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) ins_rd_req = ~ins_rd_req;
         if (!ins_rd_req || $urandom_range(0, 3) == 0) ins_rd_addr = 16'($urandom);
         dat_rw_addr = 16'($urandom);
         dat_wr_data = 16'($urandom);
         tick();
      end
      reset      = 1'b0;
      ins_rd_req = 1'b0;
      dat_rd_req = 1'b0;
      dat_wr_req = 1'b0;
      idle(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
